// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared digit config type, reset constants and hex-to-segment table.
package sevenseg_pkg;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] hex;
    } digit_cfg_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam digit_cfg_t DIGIT_RESET = '{blank: 1'b1, dp: 1'b0, hex: 4'h0};

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        case (hex)
            4'h0: hex2seg = 7'h40;
            4'h1: hex2seg = 7'h79;
            4'h2: hex2seg = 7'h24;
            4'h3: hex2seg = 7'h30;
            4'h4: hex2seg = 7'h19;
            4'h5: hex2seg = 7'h12;
            4'h6: hex2seg = 7'h02;
            4'h7: hex2seg = 7'h78;
            4'h8: hex2seg = 7'h00;
            4'h9: hex2seg = 7'h10;
            4'hA: hex2seg = 7'h08;
            4'hB: hex2seg = 7'h03;
            4'hC: hex2seg = 7'h46;
            4'hD: hex2seg = 7'h21;
            4'hE: hex2seg = 7'h06;
            default: hex2seg = 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// sevenseg_hex_decode: combinational 4-to-7 active-low segment decoder.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex2seg(hex_i);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous
// staging commit, brightness PWM and a dark guard cycle at each slot start.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int NUM_DIGITS = 8,
    parameter int DIM_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_addr,
    input  logic [5:0]            wr_data,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int P  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CW = (P > 2) ? $clog2(P) : 1;
    localparam int DW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (P < 2) begin : g_bad_period
            $error("sevenseg_scan_ctrl: slot period must be at least 2 cycles");
        end
    endgenerate

    logic [CW-1:0]         slot_q, slot_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic                  ready_en_q;
    digit_cfg_t            stage_q  [NUM_DIGITS];
    digit_cfg_t            stage_d  [NUM_DIGITS];
    digit_cfg_t            active_q [NUM_DIGITS];
    digit_cfg_t            active_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d, seg_dec;
    logic                  dp_q, dp_d;
    logic                  commit, slot_end, lit;
    logic [31:0]           thr;
    digit_cfg_t            cur;

    assign slot_end   = slot_q == CW'(P - 1);
    assign commit     = slot_end && (digit_q == DW'(NUM_DIGITS - 1));
    assign wr_ready   = ready_en_q & ~commit;
    assign frame_tick = commit;
    assign cur        = active_q[digit_q];
    assign thr        = ((32'(brightness) + 32'd1) * 32'(P - 1)) >> DIM_BITS;
    // Slot 0 is always dark so the previous digit's anode fully releases first
    assign lit        = (slot_q != '0) && (32'(slot_q) <= thr) && !cur.blank;

    sevenseg_hex_decode u_dec (
        .hex_i (cur.hex),
        .seg_o (seg_dec)
    );

    always_comb begin
        slot_d   = slot_end ? '0 : slot_q + 1'b1;
        digit_d  = !slot_end ? digit_q : (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
        stage_d  = stage_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (wr_valid && wr_ready && (32'(wr_addr) == i))
                stage_d[i] = digit_cfg_t'(wr_data);
        active_d = commit ? stage_q : active_q;
        an_d     = lit ? ~(NUM_DIGITS'(1) << digit_q) : '1;
        seg_d    = lit ? seg_dec : SEG_OFF;
        dp_d     = lit ? ~cur.dp : 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q     <= '0;
            digit_q    <= '0;
            ready_en_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stage_q[i]  <= DIGIT_RESET;
                active_q[i] <= DIGIT_RESET;
            end
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            slot_q     <= slot_d;
            digit_q    <= digit_d;
            ready_en_q <= 1'b1;
            stage_q    <= stage_d;
            active_q   <= active_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: scoreboard bench; a cycle model pushes expected
// registered outputs each cycle and they are popped after the clock edge.
module tb_sevenseg_scan_ctrl;

    localparam int P = 4;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [3:0] brightness = '0;
    logic       wr_ready;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    sevenseg_scan_ctrl #(
        .CLK_HZ     (3200),
        .REFRESH_HZ (100),
        .NUM_DIGITS (8),
        .DIM_BITS   (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    out_t       sb_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [5:0] m_stage [N];
    logic [5:0] m_act   [N];
    int         m_slot, m_dig;
    bit         m_en;
    bit         d_acc, d_tick, d_rdy;
    int         lit_cnt [N];
    int         lit_any, dig0_eight;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_stage[i] = 6'h20;
            m_act[i]   = 6'h20;
        end
        m_slot = 0;
        m_dig  = 0;
        m_en   = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) lit_cnt[i] = 0;
        lit_any    = 0;
        dig0_eight = 0;
    endtask

    task automatic cyc();
        out_t e;
        bit   commit;
        int   thr;
        bit   lit;
        @(negedge clk);
        commit = resetn && m_slot == P - 1 && m_dig == N - 1;
        d_rdy  = wr_ready;
        d_tick = frame_tick;
        d_acc  = wr_valid && wr_ready;
        check("wr_ready", wr_ready, m_en && !commit);
        check("frame_tick", frame_tick, commit);
        e.an  = 8'hFF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (!resetn) m_reset();
        else begin
            thr = ((int'(brightness) + 1) * (P - 1)) >> 4;
            lit = m_slot != 0 && m_slot <= thr && !m_act[m_dig][5];
            if (lit) begin
                e.an  = ~(8'd1 << m_dig);
                e.seg = hex_tbl[m_act[m_dig][3:0]];
                e.dp  = ~m_act[m_dig][4];
            end
            if (wr_valid && m_en && !commit) m_stage[wr_addr] = wr_data;
            if (commit) m_act = m_stage;
            m_en = 1'b1;
            if (m_slot == P - 1) begin
                m_slot = 0;
                m_dig  = (m_dig + 1) % N;
            end else m_slot++;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("an", an, e.an);
        check("seg", seg, e.seg);
        check("dp", dp, e.dp);
        for (int i = 0; i < N; i++) if (an == ~(8'd1 << i)) lit_cnt[i]++;
        if (an != 8'hFF) lit_any++;
        if (an == 8'hFE && seg == 7'h00 && dp == 1'b0) dig0_eight++;
    endtask

    task automatic to_frame_start();
        int k = 0;
        while (!(m_slot == 0 && m_dig == 0) && k < 40) begin
            cyc();
            k++;
        end
        check("frame_sync_bound", k < 40, 1);
    endtask

    task automatic run_frame();
        clear_counts();
        repeat (N * P) cyc();
    endtask

    task automatic write(input logic [2:0] a, input logic [5:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
        check("write_hs", d_acc, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        m_reset();
        clear_counts();
        repeat (5) cyc();
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        resetn = 1'b1;
        cyc();
        check("ready_after_rst", wr_ready, 1);
        run_frame();
        check("blank_dark", lit_any, 0);

        brightness = 4'd15;
        to_frame_start();
        cyc();
        write(3'd3, 6'h05);
        clear_counts();
        to_frame_start();
        check("pre_commit_d3", lit_cnt[3], 0);
        run_frame();
        check("b15_d3_lit", lit_cnt[3], 3);

        brightness = 4'd7;
        run_frame();
        check("b7_d3_lit", lit_cnt[3], 1);
        brightness = 4'd0;
        run_frame();
        check("b0_dark", lit_any, 0);

        brightness = 4'd15;
        k = 0;
        while (!(m_dig == N - 1 && m_slot == P - 1) && k < 40) begin
            cyc();
            k++;
        end
        check("commit_sync_bound", k < 40, 1);
        wr_valid = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 6'h0A;
        cyc();
        check("commit_tick", d_tick, 1);
        check("commit_ready", d_rdy, 0);
        k = 1;
        while (!d_acc && k < 8) begin
            cyc();
            k++;
        end
        wr_valid = 1'b0;
        check("held_write_cycles", k, 2);
        clear_counts();
        to_frame_start();
        check("held_write_not_yet", lit_cnt[1], 0);
        run_frame();
        check("held_write_shown", lit_cnt[1], 3);

        write(3'd0, 6'h18);
        to_frame_start();
        run_frame();
        check("d0_eight_dp", dig0_eight, 3);
        write(3'd0, 6'h20);
        to_frame_start();
        run_frame();
        check("d0_blank", lit_cnt[0], 0);

        k = 0;
        while (an !== 8'hF7 && k < 40) begin
            cyc();
            k++;
        end
        check("d3_lit_found", an, 8'hF7);
        #2;
        resetn = 1'b0;
        #1;
        check("async_an", an, 8'hFF);
        check("async_seg", seg, 7'h7F);
        check("async_dp", dp, 1);
        check("async_ready", wr_ready, 0);
        m_reset();
        repeat (3) cyc();
        resetn = 1'b1;
        k = 0;
        d_tick = 1'b0;
        while (!d_tick && k < 40) begin
            cyc();
            k++;
        end
        check("first_tick_cycle", k, 32);
        run_frame();
        check("d3_blank_after_rst", lit_cnt[3], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
